// File: rtl/fp8_pkg.sv
// fp8_pkg: shared E4M3 constants and sequencer state encoding.
//   EXP_BITS/MAN_BITS/BIAS : default FP8 format (1 sign, 4 exp, 3 frac)
//   EXP_MAX/MAN_MAX        : field values for a saturated magnitude
//   state_e                : sequencer states
package fp8_pkg;

    localparam int EXP_BITS = 4;
    localparam int MAN_BITS = 3;
    localparam int BIAS     = (1 << (EXP_BITS - 1)) - 1;

    localparam logic [EXP_BITS-1:0] EXP_MAX = '1;
    localparam logic [MAN_BITS-1:0] MAN_MAX = '1;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } state_e;

endpackage

// File: rtl/fp8_approx_mul.sv
// fp8_approx_mul: combinational Mitchell (log-domain) FP8 multiplier.
// The fraction sum stands in for log2(1+f); a carry out of the fraction
// sum bumps the exponent and the wrapped sum is kept as the mantissa.
//   a, b : operands {sign, exp, frac}
//   p    : product, saturated to {S,0,0} or {S,all ones}
//   ovf  : exponent above the largest normal, p saturated high
//   unf  : exponent at or below zero, p flushed to signed zero
module fp8_approx_mul #(
    parameter int EXP_BITS = fp8_pkg::EXP_BITS,
    parameter int MAN_BITS = fp8_pkg::MAN_BITS,
    parameter int BIAS     = fp8_pkg::BIAS
) (
    input  logic [EXP_BITS+MAN_BITS:0] a,
    input  logic [EXP_BITS+MAN_BITS:0] b,
    output logic [EXP_BITS+MAN_BITS:0] p,
    output logic                       ovf,
    output logic                       unf
);
    import fp8_pkg::*;

    localparam int W  = EXP_BITS + MAN_BITS + 1;
    // Two extra bits: one for the Ea+Eb+carry headroom, one for sign.
    localparam int EW = EXP_BITS + 2;
    localparam logic signed [EW-1:0] E_TOP = EW'((1 << EXP_BITS) - 1);

    logic                       sgn;
    logic [EXP_BITS-1:0]        ea, eb;
    logic [MAN_BITS-1:0]        fa, fb;
    logic [MAN_BITS:0]          fsum;
    logic signed [EW-1:0]       e;

    assign sgn  = a[W-1] ^ b[W-1];
    assign ea   = a[W-2:MAN_BITS];
    assign eb   = b[W-2:MAN_BITS];
    assign fa   = a[MAN_BITS-1:0];
    assign fb   = b[MAN_BITS-1:0];
    assign fsum = {1'b0, fa} + {1'b0, fb};
    assign e    = $signed(EW'(ea)) + $signed(EW'(eb)) - $signed(EW'(BIAS))
                + $signed(EW'(fsum[MAN_BITS]));

    always_comb begin
        p   = '0;
        ovf = 1'b0;
        unf = 1'b0;
        if (ea == '0 || eb == '0) begin
            // zero/subnormal operands collapse to signed zero, unflagged
            p = {sgn, {(W-1){1'b0}}};
        end else if (e[EW-1] || e == '0) begin
            p   = {sgn, {(W-1){1'b0}}};
            unf = 1'b1;
        end else if (e > E_TOP) begin
            p   = {sgn, {(W-1){1'b1}}};
            ovf = 1'b1;
        end else begin
            p = {sgn, e[EXP_BITS-1:0], fsum[MAN_BITS-1:0]};
        end
    end

endmodule

// File: rtl/fp8_mul_sequencer.sv
// fp8_mul_sequencer: byte-serial front end for one fp8_approx_mul.
// Takes A then B over a valid/ready byte stream, registers the product and
// its {ovf,unf} flags, and holds them on a valid/ready output.
//   clk, rst_n          : clock, async active-low reset
//   in_data/valid/ready : operand byte stream (ready in LOAD_A/LOAD_B)
//   abort               : synchronous discard, back to LOAD_A
//   out_data/flags      : registered product and {ovf,unf}
//   out_valid/ready     : product handshake
//   busy                : operation in flight (LOAD_B, COMPUTE, RESULT)
//   op_count            : completed output handshakes, wrapping
module fp8_mul_sequencer #(
    parameter int EXP_BITS = fp8_pkg::EXP_BITS,
    parameter int MAN_BITS = fp8_pkg::MAN_BITS,
    parameter int BIAS     = fp8_pkg::BIAS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [EXP_BITS+MAN_BITS:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       abort,
    output logic [EXP_BITS+MAN_BITS:0] out_data,
    output logic [1:0]                 out_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [7:0]                 op_count
);
    import fp8_pkg::*;

    localparam logic [1:0] ST_LOAD_A  = LOAD_A;
    localparam logic [1:0] ST_LOAD_B  = LOAD_B;
    localparam logic [1:0] ST_COMPUTE = COMPUTE;
    localparam logic [1:0] ST_RESULT  = RESULT;

    logic [1:0]                 state;
    logic [EXP_BITS+MAN_BITS:0] a_reg, b_reg;
    logic [EXP_BITS+MAN_BITS:0] mul_p;
    logic                       mul_ovf, mul_unf;

    fp8_approx_mul #(
        .EXP_BITS (EXP_BITS),
        .MAN_BITS (MAN_BITS),
        .BIAS     (BIAS)
    ) u_mul (
        .a   (a_reg),
        .b   (b_reg),
        .p   (mul_p),
        .ovf (mul_ovf),
        .unf (mul_unf)
    );

    // Decoded from state only, so nothing here follows in_valid/out_ready.
    assign in_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign busy     = (state != ST_LOAD_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD_A;
            a_reg     <= '0;
            b_reg     <= '0;
            out_data  <= '0;
            out_flags <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else if (abort) begin
            // abort beats any handshake in the same cycle; the last
            // product stays on out_data/out_flags for inspection
            state     <= ST_LOAD_A;
            a_reg     <= '0;
            b_reg     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: if (in_valid) begin
                    a_reg <= in_data;
                    state <= ST_LOAD_B;
                end
                ST_LOAD_B: if (in_valid) begin
                    b_reg <= in_data;
                    state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    out_data  <= mul_p;
                    out_flags <= {mul_ovf, mul_unf};
                    out_valid <= 1'b1;
                    state     <= ST_RESULT;
                end
                ST_RESULT: if (out_ready) begin
                    out_valid <= 1'b0;
                    op_count  <= op_count + 8'd1;
                    state     <= ST_LOAD_A;
                end
                default: state <= ST_LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_mul_sequencer.sv
// tb_fp8_mul_sequencer: directed + randomized bench for fp8_mul_sequencer.
// The reference multiplies in the log domain: each operand is taken as
// (exp-bias) + frac/8 in eighths, the logs are added, and the integer and
// fractional parts of the sum give the result exponent and mantissa.
module tb_fp8_mul_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       abort;
    logic [7:0] out_data;
    logic [1:0] out_flags;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    always #5 clk = ~clk;

    fp8_mul_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .abort     (abort),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // returns {ovf, unf, product}
    function automatic logic [9:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int ea, eb, fa, fb, l, e, m;
        logic s;
        s  = a[7] ^ b[7];
        ea = int'(a[6:3]);  eb = int'(b[6:3]);
        fa = int'(a[2:0]);  fb = int'(b[2:0]);
        if (ea == 0 || eb == 0) return {2'b00, s, 7'd0};
        // log2 of the product in eighths, offset by +128 to stay positive
        l = (ea - 7) * 8 + fa + (eb - 7) * 8 + fb + 128;
        e = l / 8 - 16 + 7;
        m = l % 8;
        if (e <= 0)  return {2'b01, s, 7'd0};
        if (e > 15)  return {2'b10, s, 7'h7f};
        return {2'b00, s, e[3:0], m[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        chk("in_ready_push", in_ready, 1'b1);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full operation with fixed-latency checks and optional backpressure.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [9:0] r;
        r = ref_mul(a, b);
        push(a);
        chk("busy_load_b", busy, 1'b1);
        push(b);
        chk("valid_compute", out_valid, 1'b0);
        tick();
        chk("valid_result", out_valid, 1'b1);
        chk("out_data", out_data, r[7:0]);
        chk("out_flags", out_flags, r[9:8]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;           // must be ignored in RESULT
            in_data  = 8'($urandom);
            tick();
            chk("hold_data", out_data, r[7:0]);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_busy", busy, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        cnt = (cnt + 1) % 256;
        chk("valid_cleared", out_valid, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
        chk("op_count", op_count, cnt[7:0]);
    endtask

    initial begin
        logic [9:0] r;
        logic [7:0] last_data;
        logic [1:0] last_flags;

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_flags", out_flags, 2'b00);
        chk("rst_count", op_count, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // directed arithmetic
        run_op(8'h38, 8'h38, 0);
        chk("one_x_one", out_data, 8'h38);
        run_op(8'h3C, 8'h3C, 0);
        chk("carry_1p5", out_data, 8'h40);
        run_op(8'hC0, 8'h3A, 0);
        chk("neg_mul", {out_flags, out_data}, {2'b00, 8'hC2});
        run_op(8'h7F, 8'h7F, 0);
        chk("ovf_sat", {out_flags, out_data}, {2'b10, 8'h7F});
        run_op(8'h08, 8'h08, 0);
        chk("unf_flush", {out_flags, out_data}, {2'b01, 8'h00});
        run_op(8'h80, 8'h38, 0);
        chk("zero_in", {out_flags, out_data}, {2'b00, 8'h80});

        // backpressure
        run_op(8'h45, 8'hB3, 5);

        // abort in LOAD_B, coincident with an input handshake
        push(8'h50);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h50;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_lb_busy", busy, 1'b0);
        chk("abort_lb_valid", out_valid, 1'b0);
        chk("abort_lb_count", op_count, cnt[7:0]);
        run_op(8'h3C, 8'h3C, 0);       // stale A would change this result
        chk("abort_lb_fresh", out_data, 8'h40);

        // abort in COMPUTE: output registers keep the previous product
        last_data = out_data; last_flags = out_flags;
        push(8'h7F); push(8'h7F);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_co_valid", out_valid, 1'b0);
        chk("abort_co_busy", busy, 1'b0);
        chk("abort_co_data", {out_flags, out_data}, {last_flags, last_data});
        chk("abort_co_count", op_count, cnt[7:0]);

        // abort in RESULT, first alone, then with the output handshake
        for (int k = 0; k < 2; k++) begin
            r = ref_mul(8'h48, 8'h39);
            push(8'h48); push(8'h39);
            tick();
            chk("abort_rs_pre", out_valid, 1'b1);
            abort = 1'b1; out_ready = (k == 1);
            tick();
            abort = 1'b0; out_ready = 1'b0;
            chk("abort_rs_valid", out_valid, 1'b0);
            chk("abort_rs_busy", busy, 1'b0);
            chk("abort_rs_data", out_data, r[7:0]);
            chk("abort_rs_count", op_count, cnt[7:0]);
        end

        // randomized run; op_count wraps through 255->0 inside this loop
        for (int i = 0; i < 256; i++)
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)));
        chk("wrap_count", op_count, cnt[7:0]);

        // make sure out_data is non-zero so the reset check means something
        run_op(8'h38, 8'h38, 0);

        // async reset mid-LOAD_B
        push(8'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 8'h00);
        chk("arst_flags", out_flags, 2'b00);
        chk("arst_count", op_count, 8'h00);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        tick();
        run_op(8'h38, 8'h38, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp8_mul_sequencer.md
# fp8_mul_sequencer

Byte-serial controller that sequences one E4M3 approximate (Mitchell log-domain) FP8 multiplier behind the tile's 8-bit pins. It accepts operand A then operand B over a valid/ready byte stream and fires the combinational multiplier once. It registers the product with overflow and underflow saturation and presents it on a valid/ready output. The top-level wrapper maps these ports onto ui_in, uo_out and uio.

## Interface
- EXP_BITS, 4, exponent width
- MAN_BITS, 3, mantissa fraction width (EXP_BITS+MAN_BITS+1 = 8)
- BIAS, 7, exponent bias, (1<<(EXP_BITS-1))-1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_data  in  8  operand byte {sign, exp, man}
- in_valid  in  1  in_data valid
- in_ready  out  1  high in LOAD_A/LOAD_B
- abort  in  1  synchronous discard of the current operation
- out_data  out  8  registered product
- out_flags  out  2  {ovf, unf} for out_data
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- busy  out  1  high in LOAD_B, COMPUTE, RESULT
- op_count  out  8  completed output handshakes, wraps 255->0

## Operation
- States: LOAD_A -> LOAD_B -> COMPUTE -> RESULT -> LOAD_A.
- LOAD_A: in_valid&&in_ready captures A and moves to LOAD_B.
- LOAD_B: the same handshake captures B and moves to COMPUTE.
- COMPUTE: lasts one cycle. Registers out_data and out_flags, sets out_valid, moves to RESULT.
- RESULT: holds out_data, out_flags and out_valid stable until out_valid&&out_ready. Then it clears out_valid, increments op_count and moves to LOAD_A.
- Arithmetic:
  - S = Sa^Sb.
  - s = fa+fb, MAN_BITS+1 bits wide.
  - E = Ea+Eb-BIAS+s[MAN_BITS], signed, EXP_BITS+2 bits wide.
  - M = s[MAN_BITS-1:0] in both the carry and no-carry case.
- Special cases, in priority order:
  - Either Ea==0: result {S,0,0}. Zero or subnormal input is treated as zero, no flag.
  - Else E<=0: result {S,0,0}, unf=1.
  - Else E>2^EXP_BITS-1: result {S,all ones,all ones}, ovf=1.
  - Otherwise: result {S,E[EXP_BITS-1:0],M}.
- All-ones exponent is an ordinary normal value (no Inf/NaN).
- abort, any state: next state LOAD_A, captured operands discarded, out_valid=0 next cycle. out_data and out_flags keep their last values.
- abort in the same cycle as the output handshake: abort wins, op_count not incremented.
- abort in the same cycle as an input handshake: byte discarded, state LOAD_A.
- in_valid outside LOAD_A/LOAD_B is ignored. out_ready outside RESULT is ignored.

## Timing
- Reset values: state LOAD_A, in_ready=1, busy=0, out_valid=0, out_data=0x00, out_flags=0, op_count=0.
- rst_n deassertion mid-operation behaves identically to reset; no partial result is emitted.
- Byte-in throughput: one byte per cycle while in_ready=1.
- Latency: B accepted at edge N -> COMPUTE during cycle N..N+1 -> out_valid=1 from edge N+1.
- Output handshake at edge M -> in_ready=1 from edge M.
- Best-case period: 4 cycles per product.
- in_ready is combinational from the state register only. No output depends combinationally on in_valid or out_ready.

## Structure
- Shared package fp8_pkg holds the E4M3 constants (EXP_BITS, MAN_BITS, BIAS), the state enum {LOAD_A, LOAD_B, COMPUTE, RESULT}, and the EXP_MAX/MAN_MAX saturation constants.
- One sub-module, fp8_approx_mul:
  - Purely combinational.
  - Inputs A, B (8 bits each).
  - Outputs P (8), ovf, unf.
  - Implements the arithmetic and special-case rules above.
- The sequencer owns the FSM, the A/B operand registers, the result and flag registers, and op_count.

## Test plan
- 0x38 then 0x38 (1.0 x 1.0) -> out_data=0x38, flags=00, out_valid exactly 1 cycle after B accepted, op_count=1 after handshake.
- 0x3C x 0x3C (1.5 x 1.5, Mitchell carry) -> 0x40 (2.0). Then 0xC0 x 0x3A (-2 x 1.25) -> 0xC2, flags=00.
- 0x7F x 0x7F -> 0x7F with ovf=1. 0x08 x 0x08 -> 0x00 with unf=1. 0x80 x 0x38 -> 0x80 with flags=00.
- Backpressure: hold out_ready=0 for 5 cycles in RESULT -> out_data stable, in_ready=0, busy=1. Raise out_ready -> in_ready=1 on the next edge.
- abort asserted in LOAD_B, COMPUTE and RESULT in turn -> next cycle LOAD_A, out_valid=0, op_count unchanged. Also abort coincident with the output handshake -> op_count not incremented.
- Run 256 products, then assert rst_n=0 mid-LOAD_B:
  - op_count wraps 255->0 after the 256th.
  - Reset returns every output to its reset value asynchronously.
